// File: rtl/floo_edge_isolator.sv
// Per-channel edge buffer with drain-then-isolate control and saturating flit counters.
// Each channel is an independent valid/ready FIFO that can be quiesced without touching the others.
module floo_edge_isolator #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumChannels-1:0]          in_valid_i,
  output logic [NumChannels-1:0]          in_ready_o,
  input  logic [NumChannels*DataWidth-1:0] in_data_i,
  output logic [NumChannels-1:0]          out_valid_o,
  input  logic [NumChannels-1:0]          out_ready_i,
  output logic [NumChannels*DataWidth-1:0] out_data_o,
  input  logic [NumChannels-1:0]          isolate_i,
  output logic [NumChannels-1:0]          isolated_o,
  input  logic                            clear_cnt_i,
  output logic [NumChannels*CntWidth-1:0] flit_cnt_o
);

  localparam int unsigned AddrWidth = $clog2(FifoDepth);
  localparam int unsigned PtrWidth  = AddrWidth + 1;

  typedef enum logic [1:0] {StActive, StDrain, StIsolated} state_e;

  for (genvar c = 0; c < NumChannels; c++) begin : gen_chan
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] mem_q [FifoDepth];
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic                 empty, full, push, pop, empty_next;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrWidth-1] != rd_ptr_q[PtrWidth-1]) &&
                   (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);

    // Handshake signals depend on registered state only.
    assign in_ready_o[c]  = (state_q == StActive) && !full;
    assign out_valid_o[c] = (state_q != StIsolated) && !empty;
    assign isolated_o[c]  = (state_q == StIsolated);
    assign out_data_o[c*DataWidth +: DataWidth] = mem_q[rd_ptr_q[AddrWidth-1:0]];
    assign flit_cnt_o[c*CntWidth +: CntWidth]   = cnt_q;

    assign push = in_valid_i[c] && in_ready_o[c];
    assign pop  = out_valid_o[c] && out_ready_i[c];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      state_d  = state_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      empty_next = (wr_ptr_d == rd_ptr_d);

      if (clear_cnt_i) begin
        cnt_d = '0;
      end else if (pop && (cnt_q != {CntWidth{1'b1}})) begin
        cnt_d = cnt_q + CntWidth'(1);
      end

      unique case (state_q)
        StActive: begin
          if (isolate_i[c]) state_d = StDrain;
        end
        StDrain: begin
          // A dropped request keeps the buffered flits and resumes normal flow.
          if (!isolate_i[c])   state_d = StActive;
          else if (empty_next) state_d = StIsolated;
        end
        StIsolated: begin
          if (!isolate_i[c]) state_d = StActive;
        end
        default: state_d = StActive;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        state_q  <= StActive;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        state_q  <= state_d;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      end else if (push) begin
        mem_q[wr_ptr_q[AddrWidth-1:0]] <= in_data_i[c*DataWidth +: DataWidth];
      end
    end
  end

endmodule

// File: tb/tb_floo_edge_isolator.sv
// Self-checking bench for floo_edge_isolator: queue-based reference model, a vector table
// for fill/backpressure, directed isolation/reset sequences and randomized traffic.
module tb_floo_edge_isolator;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     in_valid = '0, in_ready, out_valid, out_ready = '1;
  logic [NC-1:0]     isolate = '0, isolated;
  logic [NC*DW-1:0]  in_data = '0, out_data;
  logic              clear_cnt = 1'b0;
  logic [NC*CW-1:0]  flit_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per channel, mode 0=active 1=draining 2=isolated.
  logic [DW-1:0] mq [NC][$];
  int            mmode [NC];
  int            mcnt [NC];

  always #5 clk = ~clk;

  floo_edge_isolator #(
    .NumChannels(NC), .DataWidth(DW), .FifoDepth(FD), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .isolate_i(isolate), .isolated_o(isolated),
    .clear_cnt_i(clear_cnt), .flit_cnt_o(flit_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      mmode[c] = 0;
      mcnt[c]  = 0;
    end
  endtask

  // Compare all outputs against the model, advance one clock, update the model.
  task automatic cycle();
    bit push [NC];
    bit pop  [NC];
    #1;
    for (int c = 0; c < NC; c++) begin
      bit er, ev;
      er = (mmode[c] == 0) && (mq[c].size() < FD);
      ev = (mmode[c] != 2) && (mq[c].size() > 0);
      chk($sformatf("in_ready[%0d]", c), in_ready[c], er);
      chk($sformatf("out_valid[%0d]", c), out_valid[c], ev);
      if (ev) chk($sformatf("out_data[%0d]", c), out_data[c*DW +: DW], mq[c][0]);
      chk($sformatf("isolated[%0d]", c), isolated[c], mmode[c] == 2);
      chk($sformatf("flit_cnt[%0d]", c), flit_cnt[c*CW +: CW], mcnt[c]);
      push[c] = in_valid[c] && er;
      pop[c]  = ev && out_ready[c];
    end
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (pop[c]) void'(mq[c].pop_front());
      if (push[c]) mq[c].push_back(in_data[c*DW +: DW]);
      if (clear_cnt) mcnt[c] = 0;
      else if (pop[c] && mcnt[c] < CntMax) mcnt[c]++;
      case (mmode[c])
        0: if (isolate[c]) mmode[c] = 1;
        1: if (!isolate[c]) mmode[c] = 0;
           else if (mq[c].size() == 0) mmode[c] = 2;
        default: if (!isolate[c]) mmode[c] = 0;
      endcase
    end
    #1;
  endtask

  task automatic idle();
    in_valid  = '0;
    out_ready = '1;
    isolate   = '0;
    clear_cnt = 1'b0;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic [CW-1:0] exp_cnt;
  } row_t;

  row_t tbl [12];

  initial begin
    // Channel 1: six pushes into a 4-deep FIFO with output stalled, then released.
    tbl[0]  = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd0, 4'd0};
    tbl[1]  = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 16'd1, 4'd0};
    tbl[2]  = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 16'd1, 4'd0};
    tbl[3]  = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b1, 16'd1, 4'd0};
    tbl[4]  = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 16'd1, 4'd0};
    tbl[5]  = '{1'b1, 16'd5, 1'b1, 1'b0, 1'b1, 16'd1, 4'd0};
    tbl[6]  = '{1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 16'd2, 4'd1};
    tbl[7]  = '{1'b1, 16'd6, 1'b1, 1'b1, 1'b1, 16'd3, 4'd2};
    tbl[8]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd4, 4'd3};
    tbl[9]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd5, 4'd4};
    tbl[10] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd6, 4'd5};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0, 4'd6};

    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("reset in_ready", in_ready, {NC{1'b1}});
    chk("reset out_valid", out_valid, '0);
    chk("reset out_data", out_data, '0);
    chk("reset isolated", isolated, '0);
    chk("reset flit_cnt", flit_cnt, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: push 0xA5 on channel 0
    in_valid[0] = 1'b1;
    in_data[0 +: DW] = 16'h00A5;
    cycle();
    in_valid[0] = 1'b0;
    chk("latency out_valid[0]", out_valid[0], 1'b1);
    chk("latency out_data[0]", out_data[0 +: DW], 16'h00A5);
    cycle();
    chk("latency flit_cnt[0]", flit_cnt[0 +: CW], 4'd1);
    cycle();

    // Fill and backpressure on channel 1
    foreach (tbl[i]) begin
      in_valid[1] = tbl[i].v;
      in_data[DW +: DW] = tbl[i].d;
      out_ready[1] = tbl[i].ordy;
      #1;
      chk($sformatf("tbl[%0d] in_ready", i), in_ready[1], tbl[i].exp_ir);
      chk($sformatf("tbl[%0d] out_valid", i), out_valid[1], tbl[i].exp_ov);
      if (tbl[i].exp_ov) chk($sformatf("tbl[%0d] out_data", i), out_data[DW +: DW], tbl[i].exp_od);
      chk($sformatf("tbl[%0d] flit_cnt", i), flit_cnt[CW +: CW], tbl[i].exp_cnt);
      cycle();
    end
    idle();

    // Isolation with drain on channel 2 while the others stream
    out_ready[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b1111;
      for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = DW'($urandom);
      in_data[2*DW +: DW] = DW'(16'h20 + i);
      cycle();
    end
    in_valid[2] = 1'b0;
    isolate[2] = 1'b1;
    out_ready[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NC; c++) if (c != 2) in_data[c*DW +: DW] = DW'($urandom);
      #1;
      if (i > 0) chk("drain in_ready[2]", in_ready[2], 1'b0);
      chk("drain out_data[2]", out_data[2*DW +: DW], DW'(16'h20 + i));
      chk("drain isolated[2] early", isolated[2], 1'b0);
      cycle();
    end
    #1;
    chk("drain isolated[2]", isolated[2], 1'b1);
    chk("drain out_valid[2]", out_valid[2], 1'b0);
    chk("drain flit_cnt[2]", flit_cnt[2*CW +: CW], 4'd3);
    isolate[2] = 1'b0;
    cycle();
    chk("release isolated[2]", isolated[2], 1'b0);
    chk("release in_ready[2]", in_ready[2], 1'b1);
    idle();
    cycle();

    // Abort drain on channel 3
    out_ready[3] = 1'b0;
    in_valid[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data[3*DW +: DW] = DW'(16'h30 + i);
      cycle();
    end
    in_valid[3] = 1'b0;
    isolate[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort isolated[3]", isolated[3], 1'b0);
    end
    isolate[3] = 1'b0;
    cycle();
    chk("abort isolated[3] after", isolated[3], 1'b0);
    chk("abort in_ready[3]", in_ready[3], 1'b1);
    out_ready[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort out_data[3]", out_data[3*DW +: DW], DW'(16'h30 + i));
      cycle();
    end
    chk("abort out_valid[3] empty", out_valid[3], 1'b0);

    // Counter saturation and clear on channel 0
    in_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data[0 +: DW] = DW'(i);
      cycle();
    end
    chk("saturate flit_cnt[0]", flit_cnt[0 +: CW], 4'd15);
    chk("clear pop pending", out_valid[0], 1'b1);
    clear_cnt = 1'b1;
    cycle();
    clear_cnt = 1'b0;
    chk("clear flit_cnt[0]", flit_cnt[0 +: CW], 4'd0);
    idle();
    repeat (3) cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NC; c++) begin
        in_valid[c]  = ($urandom_range(0, 3) != 0);
        out_ready[c] = ($urandom_range(0, 2) != 0);
        in_data[c*DW +: DW] = DW'($urandom);
        if ($urandom_range(0, 15) == 0) isolate[c] = ~isolate[c];
      end
      clear_cnt = ($urandom_range(0, 40) == 0);
      cycle();
    end

    // Asynchronous reset while flits are buffered
    idle();
    repeat (4) cycle();
    out_ready = '0;
    in_valid = '1;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = DW'($urandom | 1);
      cycle();
    end
    in_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("async in_ready", in_ready, {NC{1'b1}});
    chk("async out_valid", out_valid, '0);
    chk("async out_data", out_data, '0);
    chk("async isolated", isolated, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = '1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post-reset out_valid", out_valid, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/floo_edge_isolator.md
# floo_edge_isolator

Parametrised per-channel edge buffer and isolation unit placed between the chiplet NoC edge ports (HBM north/south/east/west groups) and the die boundary. Each of `NumChannels` independent valid/ready flit channels gets a registered FIFO, a drain-then-isolate state machine and a saturating flit counter. This allows individual edge channels to be quiesced, for example for HBM power-down or die-to-die link retraining, without disturbing the others.

## Interface
Parameters:
- `NumChannels`, 4: number of independent edge channels.
- `DataWidth`, 64: flit payload width per channel.
- `FifoDepth`, 4: entries per channel FIFO; a power of two, ≥2.
- `CntWidth`, 16: width of each per-channel flit counter.

Ports:
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `in_valid_i`  in  NumChannels  per-channel input flit valid.
- `in_ready_o`  out  NumChannels  per-channel input ready.
- `in_data_i`  in  NumChannels*DataWidth  input flits; channel c occupies bits [c*DataWidth +: DataWidth].
- `out_valid_o`  out  NumChannels  per-channel output flit valid.
- `out_ready_i`  in  NumChannels  per-channel output ready.
- `out_data_o`  out  NumChannels*DataWidth  output flits; same packing as the input.
- `isolate_i`  in  NumChannels  per-channel isolation request, level-sensitive.
- `isolated_o`  out  NumChannels  the channel is drained and isolated.
- `clear_cnt_i`  in  1  synchronous clear of all flit counters.
- `flit_cnt_o`  out  NumChannels*CntWidth  per-channel count of flits delivered on the output.

## Operation
- Channels are fully independent; only `clear_cnt_i` is shared.
- Each channel has a `FifoDepth`-entry FIFO with read and write pointers of log2(FifoDepth)+1 bits.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap naturally.
- Push occurs when `in_valid_i & in_ready_o`. Pop occurs when `out_valid_o & out_ready_i`.
- `in_ready_o` = (state == ACTIVE) & !full.
  - It depends on registered state only; there is no combinational path from `out_ready_i` or `isolate_i`.
  - A full FIFO refuses a push even when a pop happens in the same cycle.
- `out_valid_o` = !empty in ACTIVE and DRAIN; it is 0 in ISOLATED.
- `out_data_o` = the FIFO head entry. Storage resets to 0.
- Flits leave in strict arrival order. The payload is never modified.
- State machine per channel:
  - ACTIVE → DRAIN when `isolate_i` = 1.
  - DRAIN → ISOLATED when the FIFO becomes empty. The empty test uses the post-pop occupancy, so draining the last flit moves to ISOLATED at that same clock edge.
  - DRAIN → ACTIVE when `isolate_i` drops before empty; the flits still buffered are kept.
  - ISOLATED → ACTIVE when `isolate_i` = 0.
  - ACTIVE with `isolate_i` = 1 and an empty FIFO goes to DRAIN, then to ISOLATED on the next cycle.
- `isolated_o` = (state == ISOLATED).
- Counters:
  - `flit_cnt_o[c]` increments on every pop of channel c.
  - Counters saturate at 2^CntWidth−1.
  - `clear_cnt_i` sets all counters to 0 and wins over a simultaneous increment; that pop is not counted.
- Reset mid-operation discards all buffered flits. The upstream and downstream sides must treat any in-flight handshake as cancelled.

## Timing
- Reset values:
  - `in_ready_o` = all 1.
  - `out_valid_o` = 0.
  - `out_data_o` = 0.
  - `isolated_o` = 0.
  - `flit_cnt_o` = 0.
  - States = ACTIVE, FIFOs empty.
- Latency: a flit pushed at edge t is visible on `out_valid_o`/`out_data_o` in the cycle after edge t. There is no fall-through.
- Throughput: one flit per cycle per channel whenever `FifoDepth` ≥ 2 and the output is ready.
- Isolation handshake, with `isolate_i` rising in cycle k:
  - A push in cycle k is still accepted and drained.
  - `in_ready_o` = 0 from cycle k+1.
  - `isolated_o` = 1 in the cycle after the final pop edge, or at k+2 if the FIFO was already empty.
- Release: `isolate_i` falls in ISOLATED in cycle j → `isolated_o` = 0 and `in_ready_o` = 1 in cycle j+1.
- Counter update is visible one cycle after the pop.

## Test plan
- **Reset and latency:** drive reset, then push 0xA5 on channel 0 at cycle 1 with `out_ready_i` = 1 → `out_valid_o[0]` = 1 with data 0xA5 in cycle 2; `flit_cnt_o[0]` = 1 in cycle 3.
- **Fill and backpressure:** hold `out_ready_i[1]` = 0 and push 6 flits (values 1..6) at FifoDepth=4 → exactly 4 are accepted and `in_ready_o[1]` = 0. Then release `out_ready_i[1]` → output is 1, 2, 3, 4 in order, then 5 and 6 after ready returns; count = 6.
- **Isolation with drain:** buffer 3 flits on channel 2, assert `isolate_i[2]` with `out_ready_i[2]` = 1 → `in_ready_o[2]` = 0 next cycle, 3 flits delivered, `isolated_o[2]` = 1 in the cycle after the third pop. Channels 0, 1 and 3 keep streaming unaffected.
- **Abort drain:** assert `isolate_i` with 2 flits buffered and `out_ready_i` = 0, deassert after 3 cycles → back to ACTIVE, both flits later delivered, `isolated_o` never asserts.
- **Counter saturation and clear:** CntWidth=4; stream 20 flits → count holds at 15. Pulse `clear_cnt_i` concurrent with a pop → count = 0.
- **Asynchronous reset mid-stream:** assert `rst_i` between clock edges while flits are buffered → outputs immediately return to reset values, and no buffered flit appears after release.
